// File: rtl/lat_echo_pkg.sv
// Shared types and constants for the link-latency echo responder.
// Holds the FSM state encoding, counter widths and default geometry.
// No logic beyond a saturating-increment helper for the statistics counters.
package lat_echo_pkg;

  localparam int TURN_W     = 14;
  localparam int CNT_W      = 16;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_DEPTH  = 256;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RECV = 3'd1,
    ST_WAIT = 3'd2,
    ST_SEND = 3'd3,
    ST_DROP = 3'd4
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/lat_echo_buf.sv
// Frame buffer: simple dual-port RAM, one write port, one read port.
// Latency: read data appears the cycle after rd_en_i; it holds while rd_en_i is low.
// Backpressure: none here; the caller stalls by withholding rd_en_i.
// Ports: clk; wr_en_i/wr_addr_i/wr_dat_i write port; rd_en_i/rd_addr_i/rd_dat_o read port.
module lat_echo_buf
  import lat_echo_pkg::*;
#(
  parameter int W      = DEF_DATA_W + DEF_DATA_W / 8,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [W-1:0]      wr_dat_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [W-1:0]      rd_dat_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rd_dat_q;

  // No reset on the array or read register: contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_dat_i;
    if (rd_en_i) rd_dat_q <= mem_q[rd_addr_i];
  end

  assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/lat_echo_responder.sv
// Far-end latency-test responder: stores one s_axis frame, waits i_turnaround cycles, replays it on m_axis.
// Latency: first echo beat valid 3+N cycles after the accepted ingress tlast beat; back-to-back thereafter.
// Backpressure: m_axis_tready stalls the RAM read pipeline in place; s_axis_tready low outside IDLE/RECV/DROP.
// Ports: clk, rst (sync, active-high), test_mode, i_turnaround, s_axis_* ingress, m_axis_* echo,
//        o_echo_cnt / o_drop_cnt saturating statistics, o_busy (state != IDLE).
module lat_echo_responder
  import lat_echo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int KEEP_W = DATA_W / 8,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              test_mode,
  input  logic [TURN_W-1:0] i_turnaround,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [KEEP_W-1:0] s_axis_tkeep,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic [CNT_W-1:0]  o_echo_cnt,
  output logic [CNT_W-1:0]  o_drop_cnt,
  output logic              o_busy
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   last_addr_q, last_addr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [TURN_W-1:0]   turn_q, turn_d;
  logic                issue_done_q, issue_done_d;
  logic                ram_vld_q, ram_vld_d;
  logic                ram_last_q, ram_last_d;
  logic                m_vld_q, m_vld_d;
  logic                m_last_q, m_last_d;
  logic [DATA_W-1:0]   m_dat_q, m_dat_d;
  logic [KEEP_W-1:0]   m_keep_q, m_keep_d;
  logic [CNT_W-1:0]    echo_cnt_q, echo_cnt_d;
  logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
  logic                rst_hold_q;

  logic                s_rdy, s_acc, m_xfer, out_load, issue, rd_en, wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W+KEEP_W-1:0] ram_dat;

  // rst_hold_q keeps ingress closed in the cycle right after reset is sampled.
  assign s_rdy    = !rst_hold_q &&
                    ((state_q == ST_IDLE && test_mode) || state_q == ST_RECV || state_q == ST_DROP);
  assign s_acc    = s_axis_tvalid && s_rdy;
  assign m_xfer   = m_vld_q && m_axis_tready;
  assign out_load = !m_vld_q || m_axis_tready;
  // Reads start in the last WAIT cycle so the first beat reaches the output register on time.
  assign issue    = (state_q == ST_SEND && !issue_done_q) || (state_q == ST_WAIT && turn_q == '0);
  assign rd_en    = issue && (!ram_vld_q || out_load);
  assign wr_en    = s_acc && (state_q != ST_DROP);
  assign wr_addr  = (state_q == ST_IDLE) ? '0 : wr_ptr_q;

  lat_echo_buf #(
    .W      (DATA_W + KEEP_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_dat_i  ({s_axis_tkeep, s_axis_tdata}),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_ptr_q),
    .rd_dat_o  (ram_dat)
  );

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    last_addr_d = last_addr_q;
    turn_d      = turn_q;
    echo_cnt_d  = echo_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    case (state_q)
      ST_IDLE: if (s_acc) begin
        wr_ptr_d = ADDR_W'(1);
        if (s_axis_tlast) begin
          last_addr_d = '0;
          turn_d      = i_turnaround;
          state_d     = ST_WAIT;
        end else begin
          state_d = ST_RECV;
        end
      end
      ST_RECV: if (s_acc) begin
        if (s_axis_tlast) begin
          last_addr_d = wr_ptr_q;
          turn_d      = i_turnaround;
          state_d     = ST_WAIT;
        end else if (wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
          // Buffer full and the frame continues: it cannot be echoed whole.
          state_d = ST_DROP;
        end else begin
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
      end
      ST_DROP: if (s_acc && s_axis_tlast) begin
        drop_cnt_d = sat_inc(drop_cnt_q);
        state_d    = ST_IDLE;
      end
      ST_WAIT: begin
        if (turn_q == '0) state_d = ST_SEND;
        else              turn_d  = turn_q - TURN_W'(1);
      end
      ST_SEND: if (m_xfer && m_last_q) begin
        echo_cnt_d = sat_inc(echo_cnt_q);
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Two-stage read pipeline: RAM output register, then the m_axis output register.
  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    issue_done_d = issue_done_q;
    ram_vld_d    = ram_vld_q;
    ram_last_d   = ram_last_q;
    m_vld_d      = m_vld_q;
    m_last_d     = m_last_q;
    m_dat_d      = m_dat_q;
    m_keep_d     = m_keep_q;
    if (state_q != ST_WAIT && state_q != ST_SEND) begin
      rd_ptr_d     = '0;
      issue_done_d = 1'b0;
    end
    if (rd_en) begin
      rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
      ram_vld_d  = 1'b1;
      ram_last_d = (rd_ptr_q == last_addr_q);
      if (rd_ptr_q == last_addr_q) issue_done_d = 1'b1;
    end else if (out_load) begin
      ram_vld_d = 1'b0;
    end
    if (out_load) begin
      m_vld_d  = ram_vld_q;
      m_last_d = ram_vld_q && ram_last_q;
      if (ram_vld_q) begin
        m_dat_d  = ram_dat[DATA_W-1:0];
        m_keep_d = ram_dat[DATA_W+KEEP_W-1:DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      last_addr_q  <= '0;
      rd_ptr_q     <= '0;
      turn_q       <= '0;
      issue_done_q <= 1'b0;
      ram_vld_q    <= 1'b0;
      ram_last_q   <= 1'b0;
      m_vld_q      <= 1'b0;
      m_last_q     <= 1'b0;
      m_dat_q      <= '0;
      m_keep_q     <= '0;
      echo_cnt_q   <= '0;
      drop_cnt_q   <= '0;
      rst_hold_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      last_addr_q  <= last_addr_d;
      rd_ptr_q     <= rd_ptr_d;
      turn_q       <= turn_d;
      issue_done_q <= issue_done_d;
      ram_vld_q    <= ram_vld_d;
      ram_last_q   <= ram_last_d;
      m_vld_q      <= m_vld_d;
      m_last_q     <= m_last_d;
      m_dat_q      <= m_dat_d;
      m_keep_q     <= m_keep_d;
      echo_cnt_q   <= echo_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      rst_hold_q   <= 1'b0;
    end
  end

  assign s_axis_tready = s_rdy;
  assign m_axis_tdata  = m_dat_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tvalid = m_vld_q;
  assign m_axis_tlast  = m_last_q;
  assign o_echo_cnt    = echo_cnt_q;
  assign o_drop_cnt    = drop_cnt_q;
  assign o_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lat_echo_responder.sv
// Directed bench for lat_echo_responder: echo timing, turnaround, backpressure,
// size limits, test_mode gating and mid-echo reset.
module tb_lat_echo_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        test_mode;
  logic [13:0] i_turnaround;
  logic [63:0] s_dat;
  logic [7:0]  s_keep;
  logic        s_vld, s_last, s_rdy;
  logic [63:0] m_dat;
  logic [7:0]  m_keep;
  logic        m_vld, m_last, m_rdy;
  logic [15:0] echo_cnt, drop_cnt;
  logic        busy;

  lat_echo_responder dut (
    .clk(clk), .rst(rst), .test_mode(test_mode), .i_turnaround(i_turnaround),
    .s_axis_tdata(s_dat), .s_axis_tkeep(s_keep), .s_axis_tvalid(s_vld),
    .s_axis_tlast(s_last), .s_axis_tready(s_rdy),
    .m_axis_tdata(m_dat), .m_axis_tkeep(m_keep), .m_axis_tvalid(m_vld),
    .m_axis_tlast(m_last), .m_axis_tready(m_rdy),
    .o_echo_cnt(echo_cnt), .o_drop_cnt(drop_cnt), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Ingress frame to drive, filled by each test.
  logic [63:0] in_dat[$];
  logic [7:0]  in_keep[$];

  // Echo-side observations, written only by the monitor.
  logic [63:0] rx_dat[$];
  logic [7:0]  rx_keep[$];
  logic        rx_last[$];
  int          rx_cyc[$];
  int          rise_q[$];
  int          stall_err = 0;
  logic        prev_stall = 1'b0, prev_vld = 1'b0, prev_last = 1'b0;
  logic [63:0] prev_dat = '0;
  logic [7:0]  prev_keep = '0;

  // m_axis_tready source: fixed level or the repeating 1,0,0,1,0,1 pattern.
  logic       bp_mode = 1'b0;
  logic       rdy_force = 1'b1;
  logic [5:0] pat = 6'b101001;
  always @(posedge clk) begin
    #2;
    m_rdy = bp_mode ? pat[cyc % 6] : rdy_force;
  end

  always @(negedge clk) begin
    if (m_vld && !prev_vld) rise_q.push_back(cyc);
    if (prev_stall && (!m_vld || m_dat !== prev_dat || m_keep !== prev_keep || m_last !== prev_last))
      stall_err++;
    prev_stall = m_vld && !m_rdy;
    prev_vld   = m_vld;
    prev_dat   = m_dat;
    prev_keep  = m_keep;
    prev_last  = m_last;
    if (m_vld && m_rdy) begin
      rx_dat.push_back(m_dat);
      rx_keep.push_back(m_keep);
      rx_last.push_back(m_last);
      rx_cyc.push_back(cyc);
    end
  end

  // Drives in_dat/in_keep as one frame; returns the cycle its tlast beat was accepted.
  task automatic drive_frame(input int drop_tm_at, output int t_last, output int stalls);
    int  n;
    bit  acc;
    int  w;
    n      = in_dat.size();
    stalls = 0;
    t_last = -1;
    for (int i = 0; i < n; i++) begin
      if (i == drop_tm_at) test_mode = 1'b0;
      s_vld  = 1'b1;
      s_dat  = in_dat[i];
      s_keep = in_keep[i];
      s_last = (i == n - 1);
      acc = 1'b0;
      w   = 0;
      while (!acc && w < 50) begin
        @(negedge clk);
        acc = s_rdy;
        if (acc && i == n - 1) t_last = cyc;
        if (!acc) stalls++;
        @(posedge clk); #1;
        w++;
      end
      if (!acc) begin
        vectors++; miscompares++;
        $display("FAIL drive_beat%0d: s_axis_tready stayed %0b, required 1 within 50 cycles", i, s_rdy);
        break;
      end
    end
    s_vld  = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic wait_rx(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (rx_dat.size() >= target) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; test_mode = 1'b1; i_turnaround = '0;
    s_vld = 1'b0; s_last = 1'b0; s_dat = '0; s_keep = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    vectors++; if (m_vld !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid: got %0b want 0", m_vld); end
    vectors++; if (s_rdy !== 1'b0) begin miscompares++; $display("FAIL reset_tready: got %0b want 0", s_rdy); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b want 0", busy); end
    vectors++; if (echo_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      miscompares++; $display("FAIL reset_cnts: echo %0d drop %0d want 0 0", echo_cnt, drop_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    vectors++; if (s_rdy !== 1'b1) begin miscompares++; $display("FAIL idle_tready: got %0b want 1", s_rdy); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int t, st, base, rb, got;
    bit ok;
    logic [63:0] exp [4];
    exp[0] = 64'h11; exp[1] = 64'h22; exp[2] = 64'h33; exp[3] = 64'h44;
    in_dat.delete(); in_keep.delete();
    for (int i = 0; i < 4; i++) begin in_dat.push_back(exp[i]); in_keep.push_back(8'hFF); end
    i_turnaround = 14'd0;
    base = rx_dat.size(); rb = rise_q.size();
    drive_frame(-1, t, st);
    wait_rx(base + 4, 50, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL basic_count: got %0d beats want 4", rx_dat.size() - base); end
    got = (rise_q.size() > rb) ? rise_q[rb] : -1;
    vectors++; if (got !== t + 3) begin miscompares++; $display("FAIL basic_latency: first tvalid cycle %0d want %0d", got, t + 3); end
    if (ok) for (int i = 0; i < 4; i++) begin
      vectors++;
      if (rx_dat[base+i] !== exp[i] || rx_keep[base+i] !== 8'hFF || rx_last[base+i] !== (i == 3) ||
          rx_cyc[base+i] !== t + 3 + i) begin
        miscompares++;
        $display("FAIL basic_beat%0d: got %h/%h/%0b@%0d want %h/ff/%0b@%0d", i, rx_dat[base+i],
                 rx_keep[base+i], rx_last[base+i], rx_cyc[base+i], exp[i], (i == 3), t + 3 + i);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (echo_cnt !== 16'd1) begin miscompares++; $display("FAIL basic_echo_cnt: got %0d want 1", echo_cnt); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_idle: busy %0b want 0", busy); end
  endtask

  task automatic test_turnaround();
    int t, st, base, rb, got, bad;
    bit done;
    in_dat.delete(); in_keep.delete();
    in_dat.push_back(64'hAB); in_keep.push_back(8'h0F);
    i_turnaround = 14'd100;
    base = rx_dat.size(); rb = rise_q.size();
    drive_frame(-1, t, st);
    bad = 0; done = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk); #1;
      if (s_rdy) bad++;
      if (rx_dat.size() > base) begin done = 1'b1; break; end
    end
    @(posedge clk); #1;
    vectors++; if (bad != 0 || !done) begin
      miscompares++; $display("FAIL turn_tready_low: %0d cycles with tready=1, echo_done %0b; want 0, 1", bad, done);
    end
    got = (rise_q.size() > rb) ? rise_q[rb] : -1;
    vectors++; if (got !== t + 103) begin miscompares++; $display("FAIL turn_latency: first tvalid cycle %0d want %0d", got, t + 103); end
    if (done) begin
      vectors++;
      if (rx_dat[base] !== 64'hAB || rx_keep[base] !== 8'h0F || rx_last[base] !== 1'b1) begin
        miscompares++;
        $display("FAIL turn_beat: got %h/%h/%0b want ab/0f/1", rx_dat[base], rx_keep[base], rx_last[base]);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (echo_cnt !== 16'd2) begin miscompares++; $display("FAIL turn_echo_cnt: got %0d want 2", echo_cnt); end
  endtask

  task automatic test_back_to_back_bp();
    int t, st, base, se0;
    bit ok;
    in_dat.delete(); in_keep.delete();
    for (int i = 0; i < 8; i++) begin
      in_dat.push_back(64'hA5A5_0000_0000_0000 | 64'(i * 3 + 1));
      in_keep.push_back(8'hFF >> i);
    end
    i_turnaround = 14'd2;
    bp_mode = 1'b1;
    base = rx_dat.size(); se0 = stall_err;
    drive_frame(-1, t, st);
    wait_rx(base + 8, 200, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL bp_count: got %0d beats want 8", rx_dat.size() - base); end
    if (ok) for (int i = 0; i < 8; i++) begin
      vectors++;
      if (rx_dat[base+i] !== (64'hA5A5_0000_0000_0000 | 64'(i * 3 + 1)) ||
          rx_keep[base+i] !== (8'hFF >> i) || rx_last[base+i] !== (i == 7)) begin
        miscompares++;
        $display("FAIL bp_beat%0d: got %h/%h/%0b want %h/%h/%0b", i, rx_dat[base+i], rx_keep[base+i],
                 rx_last[base+i], 64'hA5A5_0000_0000_0000 | 64'(i * 3 + 1), 8'hFF >> i, (i == 7));
      end
    end
    repeat (10) @(posedge clk);
    #1;
    vectors++; if (stall_err != se0) begin miscompares++; $display("FAIL bp_stable: %0d unstable stall cycles want 0", stall_err - se0); end
    vectors++; if (rx_dat.size() != base + 8) begin miscompares++; $display("FAIL bp_exact: %0d transfers want 8", rx_dat.size() - base); end
    vectors++; if (echo_cnt !== 16'd3) begin miscompares++; $display("FAIL bp_echo_cnt: got %0d want 3", echo_cnt); end
    bp_mode = 1'b0;
  endtask

  task automatic test_size_limits();
    int t, st, base, rb, bad, first_bad;
    bit ok;
    in_dat.delete(); in_keep.delete();
    for (int i = 0; i < 256; i++) begin in_dat.push_back({32'h5A5A_0000, 32'(i)}); in_keep.push_back(8'(i)); end
    i_turnaround = 14'd0;
    base = rx_dat.size();
    drive_frame(-1, t, st);
    wait_rx(base + 256, 600, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL full_count: got %0d beats want 256", rx_dat.size() - base); end
    bad = 0; first_bad = -1;
    if (ok) for (int i = 0; i < 256; i++) begin
      if (rx_dat[base+i] !== {32'h5A5A_0000, 32'(i)} || rx_keep[base+i] !== 8'(i) ||
          rx_last[base+i] !== (i == 255) || rx_cyc[base+i] !== rx_cyc[base] + i) begin
        bad++; if (first_bad < 0) first_bad = i;
      end
    end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL full_beats: %0d bad beats (first %0d) want 0", bad, first_bad); end
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (echo_cnt !== 16'd4) begin miscompares++; $display("FAIL full_echo_cnt: got %0d want 4", echo_cnt); end

    in_dat.delete(); in_keep.delete();
    for (int i = 0; i < 257; i++) begin in_dat.push_back(64'(i)); in_keep.push_back(8'hFF); end
    base = rx_dat.size(); rb = rise_q.size();
    drive_frame(-1, t, st);
    repeat (6) @(posedge clk);
    #1;
    vectors++; if (st != 0) begin miscompares++; $display("FAIL drop_tready: %0d beats saw tready=0 want 0", st); end
    vectors++; if (rise_q.size() != rb || rx_dat.size() != base) begin
      miscompares++; $display("FAIL drop_no_echo: %0d tvalid rises want 0", rise_q.size() - rb);
    end
    vectors++; if (drop_cnt !== 16'd1) begin miscompares++; $display("FAIL drop_cnt: got %0d want 1", drop_cnt); end
    vectors++; if (busy !== 1'b0 || echo_cnt !== 16'd4) begin
      miscompares++; $display("FAIL drop_idle: busy %0b echo %0d want 0 4", busy, echo_cnt);
    end
  endtask

  task automatic test_test_mode();
    int t, st, base;
    bit ok;
    test_mode = 1'b0;
    s_vld = 1'b1; s_dat = 64'hDEAD; s_keep = 8'hFF; s_last = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    vectors++; if (s_rdy !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL tm_off: tready %0b busy %0b want 0 0", s_rdy, busy);
    end
    @(posedge clk); #1;
    s_vld = 1'b0; s_last = 1'b0;
    test_mode = 1'b1;
    in_dat.delete(); in_keep.delete();
    for (int i = 0; i < 6; i++) begin in_dat.push_back(64'hF00D_0000 + 64'(i)); in_keep.push_back(8'h3C); end
    i_turnaround = 14'd5;
    base = rx_dat.size();
    drive_frame(2, t, st);
    wait_rx(base + 6, 100, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL tm_count: got %0d beats want 6", rx_dat.size() - base); end
    if (ok) for (int i = 0; i < 6; i++) begin
      vectors++;
      if (rx_dat[base+i] !== 64'hF00D_0000 + 64'(i) || rx_keep[base+i] !== 8'h3C || rx_last[base+i] !== (i == 5)) begin
        miscompares++;
        $display("FAIL tm_beat%0d: got %h/%h/%0b want %h/3c/%0b", i, rx_dat[base+i], rx_keep[base+i],
                 rx_last[base+i], 64'hF00D_0000 + 64'(i), (i == 5));
      end
    end
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    vectors++; if (echo_cnt !== 16'd5 || s_rdy !== 1'b0) begin
      miscompares++; $display("FAIL tm_after: echo %0d tready %0b want 5 0", echo_cnt, s_rdy);
    end
    @(posedge clk); #1;
    test_mode = 1'b1;
  endtask

  task automatic test_reset_mid();
    int t, st, base;
    bit ok;
    rdy_force = 1'b0;
    i_turnaround = 14'd0;
    in_dat.delete(); in_keep.delete();
    for (int i = 0; i < 16; i++) begin in_dat.push_back(64'hBEEF_0000 + 64'(i)); in_keep.push_back(8'hFF); end
    drive_frame(-1, t, st);
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    vectors++; if (busy !== 1'b1 || m_vld !== 1'b1) begin
      miscompares++; $display("FAIL rmid_sending: busy %0b tvalid %0b want 1 1", busy, m_vld);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (m_vld !== 1'b0 || s_rdy !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL rmid_outputs: tvalid %0b tready %0b busy %0b want 0 0 0", m_vld, s_rdy, busy);
    end
    vectors++; if (echo_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      miscompares++; $display("FAIL rmid_cnts: echo %0d drop %0d want 0 0", echo_cnt, drop_cnt);
    end
    @(posedge clk); #1;
    rdy_force = 1'b1;
    base = rx_dat.size();
    in_dat.delete(); in_keep.delete();
    for (int i = 0; i < 3; i++) begin in_dat.push_back(64'hC1 + 64'(i)); in_keep.push_back(8'h81); end
    drive_frame(-1, t, st);
    wait_rx(base + 3, 50, ok);
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (rx_dat.size() != base + 3) begin miscompares++; $display("FAIL rmid_count: got %0d beats want 3", rx_dat.size() - base); end
    if (ok) for (int i = 0; i < 3; i++) begin
      vectors++;
      if (rx_dat[base+i] !== 64'hC1 + 64'(i) || rx_keep[base+i] !== 8'h81 || rx_last[base+i] !== (i == 2)) begin
        miscompares++;
        $display("FAIL rmid_beat%0d: got %h/%h/%0b want %h/81/%0b", i, rx_dat[base+i], rx_keep[base+i],
                 rx_last[base+i], 64'hC1 + 64'(i), (i == 2));
      end
    end
    vectors++; if (echo_cnt !== 16'd1) begin miscompares++; $display("FAIL rmid_echo_cnt: got %0d want 1", echo_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_turnaround();
    test_back_to_back_bp();
    test_size_limits();
    test_test_mode();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
